// File: rtl/asym_fifo_n2w.sv
// Narrow-to-wide asymmetric FIFO: one DATA_WIDTH word in per write, one 2*DATA_WIDTH
// word out per read. Each wide word is two consecutive narrow writes, earliest in the
// low half. Read data is first-word fall-through and reads as zero while empty.
module asym_fifo_n2w #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic                    rd,
    output logic [2*DATA_WIDTH-1:0] r_data,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    // Storage is deliberately left without reset; validity is tracked by the pointers.
    logic [DATA_WIDTH-1:0] mem_q [Depth];

    // w_ptr counts narrow words, r_ptr counts wide words; both carry a wrap bit.
    logic [ADDR_WIDTH:0]   w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;

    logic [ADDR_WIDTH:0]   rd_base;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH-1:0] rd_idx_lo;
    logic [ADDR_WIDTH-1:0] rd_idx_hi;
    logic                  rd_acc;
    logic                  wr_acc;

    // Occupancy, flags and accept decisions, all from pre-edge pointer state.
    always_comb begin
        rd_base   = {r_ptr_q, 1'b0};
        count     = w_ptr_q - rd_base;
        empty     = (count < (ADDR_WIDTH + 1)'(2));
        full      = (count == (ADDR_WIDTH + 1)'(Depth));
        rd_idx_lo = rd_base[ADDR_WIDTH-1:0];
        rd_idx_hi = rd_idx_lo | ADDR_WIDTH'(1);
        rd_acc    = rd && !empty;
        // A read in the same cycle frees room, so a write into a full FIFO still lands.
        wr_acc    = wr && (!full || rd_acc);
    end

    // Head wide word, forced to zero while no complete pair is held.
    always_comb begin
        r_data = '0;
        if (!empty) begin
            r_data = {mem_q[rd_idx_hi], mem_q[rd_idx_lo]};
        end
    end

    // Pointer next-state.
    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        if (wr_acc) begin
            w_ptr_d = w_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            r_ptr_d = r_ptr_q + 1'b1;
        end
    end

    // Pointer registers; async reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
        end
    end

    // Narrow word storage write.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[w_ptr_q[ADDR_WIDTH-1:0]] <= w_data;
        end
    end

endmodule
